// File: rtl/alu_mdu_seq.sv
// Handshaked EX-stage ALU with iterative shift-add multiply and restoring divide.
// Plain ALU ops register their result one cycle after accept; MUL/DIV take WIDTH+1 cycles.
module alu_mdu_seq #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   aluop,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outport,
  output logic [WIDTH-1:0] hi_out,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             overflow_flag,
  output logic             div_by_zero
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [OPW-1:0] OP_SLL = OPW'(0),  OP_SRL = OPW'(1),  OP_ADD  = OPW'(2),
                             OP_SUB = OPW'(3),  OP_AND = OPW'(4),  OP_OR   = OPW'(5),
                             OP_XOR = OPW'(6),  OP_NOR = OPW'(7),  OP_SLT  = OPW'(8),
                             OP_SLTU = OPW'(9), OP_MULU = OPW'(10), OP_MUL = OPW'(11),
                             OP_DIVU = OPW'(12), OP_DIV = OPW'(13), OP_SRA = OPW'(14);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_hi_w, r_lo_w, r_b, r_a;
  logic             r_is_div, r_sgn, r_qneg, r_rneg, r_dz, r_dovf;
  logic [WIDTH-1:0] r_out, r_hi;
  logic             r_valid, r_zf, r_nf, r_ovf, r_dbz;

  logic             w_accept, w_mdu, w_is_div, w_sgn, w_last, w_load;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_sum, w_dif, w_res, w_absA, w_absB;
  logic             w_ovf;
  logic [WIDTH:0]   w_madd, w_dshift, w_dsub;
  logic [WIDTH-1:0] w_nhi, w_nlo, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_fin_out, w_fin_hi, w_ld_out, w_ld_hi;
  logic             w_fin_ovf, w_fin_dbz, w_ld_ovf, w_ld_dbz;

  assign in_ready = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_mdu    = (aluop == OP_MULU) | (aluop == OP_MUL) | (aluop == OP_DIVU) | (aluop == OP_DIV);
  assign w_is_div = (aluop == OP_DIVU) | (aluop == OP_DIV);
  assign w_sgn    = (aluop == OP_MUL) | (aluop == OP_DIV);
  assign w_absA   = (w_sgn & portA[WIDTH-1]) ? -portA : portA;
  assign w_absB   = (w_sgn & portB[WIDTH-1]) ? -portB : portB;
  assign w_sh     = portB[SHW-1:0];
  assign w_sum    = portA + portB;
  assign w_dif    = portA - portB;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (aluop)
      OP_SLL:  w_res = portA << w_sh;
      OP_SRL:  w_res = portA >> w_sh;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (portA[WIDTH-1] == portB[WIDTH-1]) & (w_sum[WIDTH-1] != portA[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = (portA[WIDTH-1] != portB[WIDTH-1]) & (w_dif[WIDTH-1] != portA[WIDTH-1]);
      end
      OP_AND:  w_res = portA & portB;
      OP_OR:   w_res = portA | portB;
      OP_XOR:  w_res = portA ^ portB;
      OP_NOR:  w_res = ~(portA | portB);
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(portA) < $signed(portB))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (portA < portB)};
      OP_SRA:  w_res = $unsigned($signed(portA) >>> w_sh);
      default: w_res = '0;
    endcase
  end

  // One iteration: hi/lo hold {partial product, multiplier} or {remainder, dividend->quotient}
  assign w_madd   = {1'b0, r_hi_w} + (r_lo_w[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_dshift = {r_hi_w, r_lo_w[WIDTH-1]};
  assign w_dsub   = w_dshift - {1'b0, r_b};

  always_comb begin
    if (r_is_div) begin
      w_nhi = w_dsub[WIDTH] ? w_dshift[WIDTH-1:0] : w_dsub[WIDTH-1:0];
      w_nlo = {r_lo_w[WIDTH-2:0], ~w_dsub[WIDTH]};
    end else begin
      w_nhi = w_madd[WIDTH:1];
      w_nlo = {w_madd[0], r_lo_w[WIDTH-1:1]};
    end
  end

  // Sign fixup on the final step; the core works on magnitudes only
  always_comb begin
    w_prod    = {w_nhi, w_nlo};
    if (r_qneg) w_prod = -w_prod;
    w_quo     = r_qneg ? -w_nlo : w_nlo;
    w_rem     = r_rneg ? -w_nhi : w_nhi;
    w_fin_out = '0;
    w_fin_hi  = '0;
    w_fin_ovf = 1'b0;
    w_fin_dbz = 1'b0;
    if (r_is_div) begin
      if (r_dz) begin
        w_fin_out = '1;
        w_fin_hi  = r_a;
        w_fin_dbz = 1'b1;
      end else begin
        w_fin_out = w_quo;
        w_fin_hi  = w_rem;
        w_fin_ovf = r_dovf;
      end
    end else begin
      w_fin_out = w_prod[WIDTH-1:0];
      w_fin_hi  = w_prod[2*WIDTH-1:WIDTH];
      w_fin_ovf = r_sgn ? (w_fin_hi != {WIDTH{w_fin_out[WIDTH-1]}}) : (w_fin_hi != '0);
    end
  end

  assign w_last   = (r_state == S_CALC) & (r_cnt == CNT_LAST);
  assign w_load   = (w_accept & ~w_mdu) | w_last;
  assign w_ld_out = (r_state == S_CALC) ? w_fin_out : w_res;
  assign w_ld_hi  = (r_state == S_CALC) ? w_fin_hi  : '0;
  assign w_ld_ovf = (r_state == S_CALC) ? w_fin_ovf : w_ovf;
  assign w_ld_dbz = (r_state == S_CALC) & w_fin_dbz;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi_w   <= '0;
      r_lo_w   <= '0;
      r_b      <= '0;
      r_a      <= '0;
      r_is_div <= 1'b0;
      r_sgn    <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_dz     <= 1'b0;
      r_dovf   <= 1'b0;
      r_out    <= '0;
      r_hi     <= '0;
      r_valid  <= 1'b0;
      r_zf     <= 1'b0;
      r_nf     <= 1'b0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept && w_mdu) begin
            r_state  <= S_CALC;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
            r_hi_w   <= '0;
            r_lo_w   <= w_is_div ? w_absA : w_absB;
            r_b      <= w_is_div ? w_absB : w_absA;
            r_a      <= portA;
            r_is_div <= w_is_div;
            r_sgn    <= w_sgn;
            r_qneg   <= w_sgn & (portA[WIDTH-1] ^ portB[WIDTH-1]);
            r_rneg   <= w_sgn & portA[WIDTH-1];
            r_dz     <= w_is_div & (portB == '0);
            r_dovf   <= (aluop == OP_DIV) & (portA == {1'b1, {(WIDTH-1){1'b0}}}) & (portB == '1);
          end else if (w_accept) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
          end else if (r_state == S_DONE && out_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        end
        S_CALC: begin
          r_hi_w <= w_nhi;
          r_lo_w <= w_nlo;
          r_cnt  <= r_cnt + SHW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_load) begin
        r_out <= w_ld_out;
        r_hi  <= w_ld_hi;
        r_zf  <= (w_ld_out == '0);
        r_nf  <= w_ld_out[WIDTH-1];
        r_ovf <= w_ld_ovf;
        r_dbz <= w_ld_dbz;
      end
    end
  end

  assign out_valid     = r_valid;
  assign outport       = r_out;
  assign hi_out        = r_hi;
  assign zero_flag     = r_zf;
  assign negative_flag = r_nf;
  assign overflow_flag = r_ovf;
  assign div_by_zero   = r_dbz;
endmodule
